// File: rtl/subneg_loader.sv
// subneg_loader
//   Boot-time image loader for the SUBNEG core. Receives a framed image
//   (length header, data words, checksum word) over a valid/ready stream,
//   writes the data words into core memory and releases the core from
//   reset only after the modular checksum of the image verifies.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                load request (honoured in IDLE, RUN, ERR)
//   in_data/in_valid     stream word and its valid
//   in_ready             loader accepts in_data this cycle
//   mem_we/addr/wdata    registered memory write port (1-cycle latency)
//   core_rst             core reset, high unless a verified image is running
//   busy/done/error      frame in progress / image running / last frame bad
module subneg_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, CSUM, RUN, ERR
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] len, count, sum;
    logic             xfer;
    logic [WIDTH-1:0] csum_chk;

    // Status outputs are pure decodes of the state register.
    assign in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign busy     = in_ready;
    assign done     = (state == RUN);
    assign error    = (state == ERR);
    assign core_rst = (state != RUN);

    assign xfer     = in_valid && in_ready;
    assign csum_chk = sum + in_data;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LEN;
            LEN: if (xfer) begin
                // Header is widened so a DEPTH beyond 2^WIDTH still compares correctly.
                if (32'(in_data) > DEPTH) state_next = ERR;
                else if (in_data == '0)   state_next = CSUM;
                else                      state_next = DATA;
            end
            DATA: if (xfer && (count == len - 1'b1)) state_next = CSUM;
            CSUM: if (xfer) state_next = (csum_chk == '0) ? RUN : ERR;
            RUN:  if (start) state_next = LEN;
            ERR:  if (start) state_next = LEN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            sum       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_next;
            // Write strobe is high only the cycle after a DATA transfer.
            mem_we <= (state == DATA) && xfer;
            if (state == LEN && xfer) begin
                len   <= in_data;
                count <= '0;
                sum   <= '0;
            end
            if (state == DATA && xfer) begin
                mem_addr  <= count;
                mem_wdata <= in_data;
                sum       <= sum + in_data;
                count     <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_subneg_loader.sv
module tb_subneg_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, in_valid;
    logic [W-1:0] in_data;
    logic         in_ready, mem_we, core_rst, busy, done, error;
    logic [W-1:0] mem_addr, mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    // Small DEPTH so the oversize-header case is reachable with 8-bit words.
    subneg_loader #(.WIDTH(W), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic         st, vl;
        logic [W-1:0] d;
        logic         rdy, we;
        logic [W-1:0] ad, wd;
        logic         crst, bsy, dn, er;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input string tag, input logic st, vl, input logic [W-1:0] d,
                     input logic rdy, we, input logic [W-1:0] ad, wd,
                     input logic crst, bsy, dn, er);
        vec_t r;
        r.tag = tag; r.st = st; r.vl = vl; r.d = d; r.rdy = rdy; r.we = we;
        r.ad = ad; r.wd = wd; r.crst = crst; r.bsy = bsy; r.dn = dn; r.er = er;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks all outputs; address/data only when a write is expected.
    task automatic chk_outs(input string tag, input logic rdy, we,
                            input logic [W-1:0] ad, wd,
                            input logic crst, bsy, dn, er);
        chk({tag, ".in_ready"}, W'(in_ready), W'(rdy));
        chk({tag, ".mem_we"},   W'(mem_we),   W'(we));
        if (we) begin
            chk({tag, ".mem_addr"},  mem_addr,  ad);
            chk({tag, ".mem_wdata"}, mem_wdata, wd);
        end
        chk({tag, ".core_rst"}, W'(core_rst), W'(crst));
        chk({tag, ".busy"},     W'(busy),     W'(bsy));
        chk({tag, ".done"},     W'(done),     W'(dn));
        chk({tag, ".error"},    W'(error),    W'(er));
        chk({tag, ".excl"},     W'(done & error), 8'h00);
    endtask

    initial begin
        // Basic load 3,05,10,20,CB
        v("b_idle",1,0,8'h00, 0,0,8'h0,8'h00, 1,0,0,0);
        v("b_len", 0,1,8'h03, 1,0,8'h0,8'h00, 1,1,0,0);
        v("b_d0",  0,1,8'h05, 1,0,8'h0,8'h00, 1,1,0,0);
        v("b_d1",  0,1,8'h10, 1,1,8'h0,8'h05, 1,1,0,0);
        v("b_d2",  0,1,8'h20, 1,1,8'h1,8'h10, 1,1,0,0);
        v("b_cs",  0,1,8'hCB, 1,1,8'h2,8'h20, 1,1,0,0);
        v("b_run", 0,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);
        // Bad checksum: same frame, last word CC
        v("k_st",  1,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);
        v("k_len", 0,1,8'h03, 1,0,8'h0,8'h00, 1,1,0,0);
        v("k_d0",  0,1,8'h05, 1,0,8'h0,8'h00, 1,1,0,0);
        v("k_d1",  0,1,8'h10, 1,1,8'h0,8'h05, 1,1,0,0);
        v("k_d2",  0,1,8'h20, 1,1,8'h1,8'h10, 1,1,0,0);
        v("k_cs",  0,1,8'hCC, 1,1,8'h2,8'h20, 1,1,0,0);
        v("k_err", 1,0,8'h00, 0,0,8'h0,8'h00, 1,0,0,1);
        // Backpressure 2,AA,55,01 with valid 1,0,0,1,0,1,1
        v("p_len", 0,1,8'h02, 1,0,8'h0,8'h00, 1,1,0,0);
        v("p_s0",  0,0,8'h00, 1,0,8'h0,8'h00, 1,1,0,0);
        v("p_s1",  0,0,8'h00, 1,0,8'h0,8'h00, 1,1,0,0);
        v("p_d0",  0,1,8'hAA, 1,0,8'h0,8'h00, 1,1,0,0);
        v("p_s2",  0,0,8'h00, 1,1,8'h0,8'hAA, 1,1,0,0);
        v("p_d1",  0,1,8'h55, 1,0,8'h0,8'h00, 1,1,0,0);
        v("p_cs",  0,1,8'h01, 1,1,8'h1,8'h55, 1,1,0,0);
        v("p_run", 0,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);
        // Empty image 0,00 then reload 1,7F,81
        v("e_st",  1,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);
        v("e_len", 0,1,8'h00, 1,0,8'h0,8'h00, 1,1,0,0);
        v("e_cs",  0,1,8'h00, 1,0,8'h0,8'h00, 1,1,0,0);
        v("e_run", 1,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);
        v("r_len", 0,1,8'h01, 1,0,8'h0,8'h00, 1,1,0,0);
        v("r_d0",  0,1,8'h7F, 1,0,8'h0,8'h00, 1,1,0,0);
        v("r_cs",  0,1,8'h81, 1,1,8'h0,8'h7F, 1,1,0,0);
        v("r_run", 1,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);
        // Oversize header 5 with DEPTH=4
        v("o_len", 0,1,8'h05, 1,0,8'h0,8'h00, 1,1,0,0);
        v("o_err", 1,0,8'h00, 0,0,8'h0,8'h00, 1,0,0,1);
        // Header == DEPTH is legal; start pulses mid-DATA are ignored
        v("m_len", 0,1,8'h04, 1,0,8'h0,8'h00, 1,1,0,0);
        v("m_d0",  0,1,8'h01, 1,0,8'h0,8'h00, 1,1,0,0);
        v("m_d1",  0,1,8'h02, 1,1,8'h0,8'h01, 1,1,0,0);
        v("m_d2",  1,1,8'h03, 1,1,8'h1,8'h02, 1,1,0,0);
        v("m_d3",  1,1,8'h04, 1,1,8'h2,8'h03, 1,1,0,0);
        v("m_cs",  0,1,8'hF6, 1,1,8'h3,8'h04, 1,1,0,0);
        v("m_run", 0,0,8'h00, 0,0,8'h0,8'h00, 0,0,1,0);

        // Reset state
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outs("reset", 0,1'b0,8'h0,8'h0, 1,0,0,0);
        chk("reset.mem_addr",  mem_addr,  8'h00);
        chk("reset.mem_wdata", mem_wdata, 8'h00);
        rst = 1'b0; in_valid = 1'b0; in_data = '0;

        foreach (tbl[i]) begin
            start = tbl[i].st; in_valid = tbl[i].vl; in_data = tbl[i].d;
            #1;
            chk_outs(tbl[i].tag, tbl[i].rdy, tbl[i].we, tbl[i].ad, tbl[i].wd,
                     tbl[i].crst, tbl[i].bsy, tbl[i].dn, tbl[i].er);
            @(negedge clk);
        end

        // Reset mid-DATA: frame 2,AA,55 with rst on the 55 transfer
        start = 1'b1; in_valid = 1'b0; @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h02; @(negedge clk);
        in_data = 8'hAA; @(negedge clk);
        in_data = 8'h55; rst = 1'b1; @(negedge clk);
        chk_outs("x_rst", 0,1'b0,8'h0,8'h0, 1,0,0,0);
        chk("x_rst.mem_addr",  mem_addr,  8'h00);
        chk("x_rst.mem_wdata", mem_wdata, 8'h00);
        rst = 1'b0;
        // Leftover stream words must be ignored in IDLE
        for (int k = 0; k < 3; k++) begin
            in_data = 8'h10 + 8'(k);
            @(negedge clk);
            chk_outs("x_idle", 0,1'b0,8'h0,8'h0, 1,0,0,0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
